// File: rtl/regfile_port_sequencer_if.sv
// Bundle between the register-file port sequencer and its fetch, register-file and ALU neighbours.
// master is the sequencer side; slave is the environment side.
interface regfile_port_sequencer_if #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
);
   logic                instr_valid;
   logic [31:0]         instr;
   logic                instr_ready;
   logic [RADDR_W-1:0]  rf_src1;
   logic [RADDR_W-1:0]  rf_src2;
   logic [DATA_W-1:0]   rf_out1;
   logic [DATA_W-1:0]   rf_out2;
   logic [RADDR_W-1:0]  rf_dest;
   logic [DATA_W-1:0]   rf_write_val;
   logic                rf_write_en;
   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [5:0]          alu_op;
   logic                alu_start;
   logic                alu_done;
   logic [DATA_W-1:0]   alu_result;
   logic                retire;
   logic                err_illegal;
   logic                err_timeout;

   modport master (
      input  instr_valid, instr, rf_out1, rf_out2, alu_done, alu_result,
      output instr_ready, rf_src1, rf_src2, rf_dest, rf_write_val, rf_write_en,
             alu_a, alu_b, alu_op, alu_start, retire, err_illegal, err_timeout
   );

   modport slave (
      output instr_valid, instr, rf_out1, rf_out2, alu_done, alu_result,
      input  instr_ready, rf_src1, rf_src2, rf_dest, rf_write_val, rf_write_en,
             alu_a, alu_b, alu_op, alu_start, retire, err_illegal, err_timeout
   );
endinterface

// File: rtl/regfile_port_sequencer.sv
// Multicycle sequencer: reads rs/rt, drives the ALU, writes back rd/rt for one MIPS instruction at a time.
// Assumes DATA_W > 16 and RADDR_W matching the 5-bit MIPS register fields.
module regfile_port_sequencer #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int ALU_TMO = 16
) (
   input logic                      clk,
   input logic                      rst,
   regfile_port_sequencer_if.master bus
);
   // state    | meaning
   // S_IDLE   | instr_ready high, waiting for an instruction
   // S_DECODE | rs/rt on the read ports, operands captured at the closing edge
   // S_EXEC   | operands held on the ALU, waiting for alu_done or timeout
   // S_WB     | single writeback cycle with retire pulse

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;

   localparam int              CNT_W    = $clog2(ALU_TMO);
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(ALU_TMO - 1);

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

   state_t             state;
   logic               ready_q;
   logic [5:0]         op_q;
   logic [15:0]        imm_q;
   logic [CNT_W-1:0]   tmo_cnt;
   logic [RADDR_W-1:0] dec_dest;
   logic [DATA_W-1:0]  dec_b;
   logic [5:0]         dec_op;

   function automatic logic op_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) ||
             (op == OP_ORI)   || (op == OP_LUI);
   endfunction

   assign bus.instr_ready = ready_q & ~rst;

   // rd/funct live inside imm_q[15:0] for R-type, so only op, rs, rt and imm16 are kept
   always_comb begin
      dec_dest = bus.rf_src2;
      dec_b    = {{(DATA_W-16){1'b0}}, imm_q};
      dec_op   = FN_OR;
      case (op_q)
         OP_RTYPE: begin
            dec_dest = imm_q[15:11];
            dec_b    = bus.rf_out2;
            dec_op   = imm_q[5:0];
         end
         OP_ADDI: begin
            dec_b  = {{(DATA_W-16){imm_q[15]}}, imm_q};
            dec_op = FN_ADD;
         end
         OP_ANDI: dec_op = FN_AND;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= S_IDLE;
         ready_q          <= 1'b1;
         op_q             <= '0;
         imm_q            <= '0;
         tmo_cnt          <= '0;
         bus.rf_src1      <= '0;
         bus.rf_src2      <= '0;
         bus.rf_dest      <= '0;
         bus.rf_write_val <= '0;
         bus.rf_write_en  <= 1'b0;
         bus.alu_a        <= '0;
         bus.alu_b        <= '0;
         bus.alu_op       <= '0;
         bus.alu_start    <= 1'b0;
         bus.retire       <= 1'b0;
         bus.err_illegal  <= 1'b0;
         bus.err_timeout  <= 1'b0;
      end else begin
         bus.rf_write_en <= 1'b0;
         bus.alu_start   <= 1'b0;
         bus.retire      <= 1'b0;
         bus.err_illegal <= 1'b0;
         bus.err_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  op_q            <= bus.instr[31:26];
                  bus.rf_src1     <= bus.instr[25:21];
                  bus.rf_src2     <= bus.instr[20:16];
                  imm_q           <= bus.instr[15:0];
                  // flagged on the accept edge so the pulse lands in the decode cycle
                  bus.err_illegal <= !op_legal(bus.instr[31:26]);
                  ready_q         <= 1'b0;
                  state           <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!op_legal(op_q)) begin
                  ready_q <= 1'b1;
                  state   <= S_IDLE;
               end else if (op_q == OP_LUI) begin
                  bus.rf_dest      <= dec_dest;
                  bus.rf_write_val <= {imm_q, {(DATA_W-16){1'b0}}};
                  bus.rf_write_en  <= (dec_dest != '0);
                  bus.retire       <= 1'b1;
                  state            <= S_WB;
               end else begin
                  bus.rf_dest   <= dec_dest;
                  bus.alu_a     <= bus.rf_out1;
                  bus.alu_b     <= dec_b;
                  bus.alu_op    <= dec_op;
                  bus.alu_start <= 1'b1;
                  tmo_cnt       <= TMO_LOAD;
                  state         <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (bus.alu_done) begin
                  bus.rf_write_val <= bus.alu_result;
                  bus.rf_write_en  <= (bus.rf_dest != '0);
                  bus.retire       <= 1'b1;
                  state            <= S_WB;
               end else if (tmo_cnt == '0) begin
                  bus.err_timeout <= 1'b1;
                  ready_q         <= 1'b1;
                  state           <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - CNT_W'(1);
               end
            end
            S_WB: begin
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Randomized scoreboard bench: an instruction-level model predicts writebacks/errors and their cycles,
// an environment regfile and ALU respond to the sequencer, and a monitor pops and compares.
module tb_regfile_port_sequencer;
   localparam int DATA_W    = 32;
   localparam int RADDR_W   = 5;
   localparam int ALU_TMO   = 16;
   localparam int K_RETIRE  = 0;
   localparam int K_ILLEGAL = 1;
   localparam int K_TIMEOUT = 2;

   typedef struct {
      int          kind;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] val;
      int          cyc;
   } ev_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  op;
      int          cyc;
   } alu_ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_port_sequencer_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) bus ();

   regfile_port_sequencer #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ALU_TMO(ALU_TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ev_t         evq[$];
   alu_ev_t     aluq[$];
   logic [31:0] regs[32];
   logic [31:0] ref_regs[32];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          alu_delay = 0;
   bit          mon_en = 1'b0;
   bit          load_regs = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // environment register file: combinational read, negedge write
   assign bus.rf_out1 = regs[bus.rf_src1];
   assign bus.rf_out2 = regs[bus.rf_src2];
   always @(negedge clk) begin
      if (load_regs) begin
         for (int i = 0; i < 32; i++) regs[i] <= ref_regs[i];
      end else if (bus.rf_write_en) begin
         regs[bus.rf_dest] <= bus.rf_write_val;
      end
   end

   function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // environment ALU: answers alu_delay cycles after alu_start (negative = never), stray dones otherwise
   bit alu_busy;
   int alu_wait;
   initial begin
      bus.alu_done   = 1'b0;
      bus.alu_result = '0;
      alu_busy       = 1'b0;
      alu_wait       = 0;
      forever begin
         @(posedge clk);
         #2;
         bus.alu_done = 1'b0;
         if (rst) alu_busy = 1'b0;
         else if (bus.alu_start) begin
            alu_busy = 1'b1;
            alu_wait = alu_delay;
         end
         if (alu_busy && alu_wait == 0) begin
            bus.alu_done   = 1'b1;
            bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
            alu_busy       = 1'b0;
         end else if (alu_busy) begin
            if (alu_wait > 0) alu_wait--;
         end else if (!rst && $urandom_range(0, 3) == 0) begin
            bus.alu_done   = 1'b1;
            bus.alu_result = $urandom;
         end
      end
   end

   // monitor
   ev_t     m_e;
   alu_ev_t m_a;
   int      m_k;
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("write_en_without_retire", 32'(bus.rf_write_en & ~bus.retire), 0);
         chk("pulse_overlap", 32'((32'(bus.alu_start) + 32'(bus.retire) + 32'(bus.err_illegal) +
                                   32'(bus.err_timeout)) > 1), 0);
         if (bus.retire || bus.err_illegal || bus.err_timeout) begin
            if (evq.size() == 0) begin
               chk("unexpected_event", {29'd0, bus.retire, bus.err_illegal, bus.err_timeout}, 0);
            end else begin
               m_e = evq.pop_front();
               m_k = bus.retire ? K_RETIRE : (bus.err_illegal ? K_ILLEGAL : K_TIMEOUT);
               chk("event_kind", m_k, m_e.kind);
               chk("event_cycle", cyc, m_e.cyc);
               if (m_e.kind == K_RETIRE) begin
                  chk("wb_write_en", 32'(bus.rf_write_en), 32'(m_e.we));
                  chk("wb_dest", 32'(bus.rf_dest), 32'(m_e.dest));
                  chk("wb_val", bus.rf_write_val, m_e.val);
               end
            end
         end
         if (bus.alu_start) begin
            if (aluq.size() == 0) begin
               chk("unexpected_alu_start", 32'(bus.alu_start), 0);
            end else begin
               m_a = aluq.pop_front();
               chk("alu_a", bus.alu_a, m_a.a);
               chk("alu_b", bus.alu_b, m_a.b);
               chk("alu_op", 32'(bus.alu_op), 32'(m_a.op));
               chk("alu_start_cycle", cyc, m_a.cyc);
            end
         end
      end
   end

   function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // called at a negedge; returns at the negedge right after the accept edge
   task automatic issue(input logic [31:0] iw, input int delay);
      int          waited;
      int          acc;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [31:0] a, b, v;
      logic [4:0]  dest;
      bit          uses_alu;
      ev_t         e;
      alu_ev_t     ae;
      waited = 0;
      while (bus.instr_ready !== 1'b1) begin
         bus.instr_valid = ($urandom_range(0, 1) == 1);
         bus.instr       = $urandom;
         @(negedge clk);
         waited++;
         if (waited > 100) begin
            chk("instr_ready_wait", 32'(bus.instr_ready), 1);
            bus.instr_valid = 1'b0;
            return;
         end
      end
      acc = cyc + 1;
      bus.instr_valid = 1'b1;
      bus.instr       = iw;
      op  = iw[31:26];
      rs  = iw[25:21];
      rt  = iw[20:16];
      rd  = iw[15:11];
      imm = iw[15:0];
      a   = ref_regs[rs];
      b   = ref_regs[rt];
      v   = '0;
      dest     = rt;
      uses_alu = 1'b1;
      e.kind = K_RETIRE; e.we = 1'b0; e.dest = '0; e.val = '0; e.cyc = 0;
      ae.a = a; ae.b = '0; ae.op = '0; ae.cyc = acc + 1;
      case (op)
         6'h00: begin
            dest  = rd;
            ae.b  = b;
            ae.op = iw[5:0];
            case (iw[5:0])
               6'h20:   v = a + b;
               6'h22:   v = a - b;
               6'h24:   v = a & b;
               6'h25:   v = a | b;
               default: v = a ^ b;
            endcase
         end
         6'h08: begin
            ae.b  = {{16{imm[15]}}, imm};
            ae.op = 6'h20;
            v     = a + {{16{imm[15]}}, imm};
         end
         6'h0C: begin
            ae.b  = {16'h0, imm};
            ae.op = 6'h24;
            v     = a & {16'h0, imm};
         end
         6'h0D: begin
            ae.b  = {16'h0, imm};
            ae.op = 6'h25;
            v     = a | {16'h0, imm};
         end
         6'h0F: begin
            uses_alu = 1'b0;
            v        = {imm, 16'h0};
            e.cyc    = acc + 1;
         end
         default: begin
            uses_alu = 1'b0;
            e.kind   = K_ILLEGAL;
            e.cyc    = acc;
         end
      endcase
      if (uses_alu) begin
         aluq.push_back(ae);
         if (delay < 0) begin
            e.kind = K_TIMEOUT;
            e.cyc  = acc + 1 + ALU_TMO;
         end else begin
            e.cyc = acc + 2 + delay;
         end
      end
      if (e.kind == K_RETIRE) begin
         e.we   = (dest != 5'd0);
         e.dest = dest;
         e.val  = v;
         if (dest != 5'd0) ref_regs[dest] = v;
      end
      evq.push_back(e);
      alu_delay = delay;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = $urandom;
   endtask

   logic [31:0] r_iw;
   logic [5:0]  r_op;
   int          r_sel;
   int          r_dly;
   logic [5:0]  r_fn;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      for (int i = 0; i < 32; i++) ref_regs[i] = $urandom;
      ref_regs[0] = 32'd0;
      ref_regs[1] = 32'd1;
      ref_regs[2] = 32'd2;
      ref_regs[3] = 32'd3;
      repeat (2) @(negedge clk);
      load_regs = 1'b0;

      chk("rst_instr_ready", 32'(bus.instr_ready), 0);
      chk("rst_pulses", {27'd0, bus.retire, bus.rf_write_en, bus.alu_start, bus.err_illegal, bus.err_timeout}, 0);
      chk("rst_write_val", bus.rf_write_val, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(bus.instr_ready), 1);

      issue(i_type(6'h08, 5'd3, 5'd5, 16'hFFFF), 0);
      issue(r_type(5'd1, 5'd2, 5'd7, 6'h20), 3);
      issue(i_type(6'h08, 5'd4, 5'd0, 16'd5), 1);
      issue(i_type(6'h0F, 5'd0, 5'd9, 16'h1234), 0);
      issue({6'h3F, 26'h2A5_5A5A}, 0);
      issue(i_type(6'h08, 5'd1, 5'd6, 16'd7), -1);

      // reset in the middle of EXEC aborts with no write, retire or error
      issue(i_type(6'h08, 5'd2, 5'd8, 16'd1), -1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      evq.delete();
      aluq.delete();
      @(negedge clk);
      chk("midrst_instr_ready", 32'(bus.instr_ready), 0);
      chk("midrst_pulses", {28'd0, bus.retire, bus.rf_write_en, bus.err_illegal, bus.err_timeout}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready_after", 32'(bus.instr_ready), 1);
      issue(r_type(5'd1, 5'd2, 5'd10, 6'h22), 2);

      for (int n = 0; n < 150; n++) begin
         r_sel = $urandom_range(0, 99);
         r_dly = $urandom_range(0, 5);
         if (r_sel < 30) begin
            case ($urandom_range(0, 4))
               0:       r_fn = 6'h20;
               1:       r_fn = 6'h22;
               2:       r_fn = 6'h24;
               3:       r_fn = 6'h25;
               default: r_fn = 6'h26;
            endcase
            r_iw = r_type(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), r_fn);
            r_iw[10:6] = 5'($urandom);
         end else if (r_sel < 75) begin
            case ($urandom_range(0, 2))
               0:       r_op = 6'h08;
               1:       r_op = 6'h0C;
               default: r_op = 6'h0D;
            endcase
            r_iw = i_type(r_op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom));
            if (r_sel >= 71) r_dly = -1;
         end else if (r_sel < 87) begin
            r_iw = i_type(6'h0F, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom));
         end else begin
            r_op = 6'($urandom);
            while (r_op == 6'h00 || r_op == 6'h08 || r_op == 6'h0C || r_op == 6'h0D || r_op == 6'h0F)
               r_op = 6'($urandom);
            r_iw = {r_op, 26'($urandom)};
         end
         issue(r_iw, r_dly);
      end

      for (int i = 0; i < 100 && (evq.size() != 0 || aluq.size() != 0); i++) @(negedge clk);
      chk("drain_events", evq.size(), 0);
      chk("drain_alu", aluq.size(), 0);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
